// File: rtl/jk_exc_pkg.sv
// jk_exc_pkg: shared definitions for the JK excitation generator.
//   DC_ZERO / DC_DSTYLE : don't-care fill policies for the excitation table.
//   jk_bit_t            : J/K pair for a single flip-flop.
//   exc_bit_t           : J/K plus toggle for a single flip-flop; the
//                         width-dependent excitation word is built from this
//                         in jk_excitation_gen, where WIDTH is known.
//   jk_excite()         : pure per-bit excitation (inverse JK table).
package jk_exc_pkg;

  localparam int unsigned DC_ZERO   = 0;
  localparam int unsigned DC_DSTYLE = 1;

  typedef struct packed {
    logic j;
    logic k;
  } jk_bit_t;

  typedef struct packed {
    logic j;
    logic k;
    logic t;
  } exc_bit_t;

  // Excitation for one flip-flop going prev -> next.
  //   0->0: J=0 K=x   0->1: J=1 K=x   1->0: J=x K=1   1->1: J=x K=0
  // DC_ZERO fills x with 0; DC_DSTYLE makes J=next, K=~next, which also
  // satisfies every row of the table.
  function automatic jk_bit_t jk_excite(input logic        prev,
                                        input logic        next,
                                        input int unsigned dc_policy);
    jk_bit_t r;
    if (dc_policy == DC_DSTYLE) begin
      r.j = next;
      r.k = ~next;
    end else begin
      r.j = ~prev & next;
      r.k = prev & ~next;
    end
    return r;
  endfunction

  function automatic exc_bit_t bit_excite(input logic        prev,
                                          input logic        next,
                                          input int unsigned dc_policy);
    exc_bit_t r;
    jk_bit_t  jk;
    jk  = jk_excite(prev, next, dc_policy);
    r.j = jk.j;
    r.k = jk.k;
    r.t = prev ^ next;
    return r;
  endfunction

endpackage

// File: rtl/jk_excitation_gen_skid_buf2.sv
// skid_buf2: generic 2-entry valid/ready buffer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : producer handshake; in_ready is a registered
//                       "not full" flag, independent of out_ready
//   in_data [PW]      : payload written on in_valid & in_ready
//   out_valid/out_ready: consumer handshake
//   out_data [PW]     : head-of-queue payload, zero when empty
// Entries leave in acceptance order. Holding in_ready low when full means
// a push never coincides with a full buffer.
module skid_buf2 #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [PW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nx;
  logic          push;
  logic          pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nx;
      // Ready for the next cycle is derived from the occupancy we are about
      // to hold, so it never depends combinationally on out_ready.
      in_ready <= (count_nx != 2'd2);
    end
  end

endmodule

// File: rtl/jk_excitation_gen.sv
// jk_excitation_gen: turns a stream of target states into J/K/T excitation
// for a WIDTH-bit bank of JK flip-flops, tracking the bank state internally.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : target handshake (in_ready registered)
//   in_target [WIDTH]   : desired next state
//   in_load             : preset the model to in_target, emit no word
//   out_valid/out_ready : excitation handshake
//   out_j/out_k [WIDTH] : J and K inputs
//   out_t [WIDTH]       : toggle mask prev ^ next
//   out_prev [WIDTH]    : model state before the transition
//   out_tcount          : popcount of out_t
module jk_excitation_gen
  import jk_exc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int unsigned      DC_POLICY = DC_ZERO
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_target,
  input  logic                         in_load,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_j,
  output logic [WIDTH-1:0]             out_k,
  output logic [WIDTH-1:0]             out_t,
  output logic [WIDTH-1:0]             out_prev,
  output logic [$clog2(WIDTH+1)-1:0]   out_tcount
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    tcount;
  } exc_word_t;

  localparam int unsigned PW = $bits(exc_word_t);

  logic [WIDTH-1:0] q;
  exc_word_t        word;
  exc_word_t        head;
  exc_bit_t         eb;
  logic [PW-1:0]    buf_out;
  logic             push_valid;
  logic             accept;

  assign accept     = in_valid & in_ready;
  // Load words share the handshake but never enter the buffer.
  assign push_valid = in_valid & ~in_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= INIT;
    else if (accept) q <= in_target;
  end

  always_comb begin
    word = '0;
    eb   = '0;
    word.prev = q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      eb = bit_excite(q[i], in_target[i], DC_POLICY);
      word.j[i] = eb.j;
      word.k[i] = eb.k;
      word.t[i] = eb.t;
      word.tcount = word.tcount + CW'(eb.t);
    end
  end

  skid_buf2 #(
    .PW (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (in_ready),
    .in_data   (word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign head       = buf_out;
  assign out_j      = head.j;
  assign out_k      = head.k;
  assign out_t      = head.t;
  assign out_prev   = head.prev;
  assign out_tcount = head.tcount;

endmodule

// File: tb/tb_jk_excitation_gen.sv
module tb_jk_excitation_gen;
  import jk_exc_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_load = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_target = '0;

  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [W-1:0] j0, k0, t0, p0, j1, k1, t1, p1;
  logic [2:0]   tc0, tc1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [W-1:0] prev;
    logic [W-1:0] tgt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  jk_excitation_gen #(.WIDTH(W), .INIT(4'b0000), .DC_POLICY(DC_ZERO)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_target(in_target), .in_load(in_load), .out_valid(out_valid0),
    .out_ready(out_ready), .out_j(j0), .out_k(k0), .out_t(t0),
    .out_prev(p0), .out_tcount(tc0));

  jk_excitation_gen #(.WIDTH(W), .INIT(4'b0000), .DC_POLICY(DC_DSTYLE)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_target(in_target), .in_load(in_load), .out_valid(out_valid1),
    .out_ready(out_ready), .out_j(j1), .out_k(k1), .out_t(t1),
    .out_prev(p1), .out_tcount(tc1));

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Offers one word and returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] tgt, input logic ld);
    int unsigned n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_target = tgt; in_load = ld;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0; in_load = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout target=%b", tgt);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid0, in_ready0, j0, k0, t0, p0, tc0} !== {1'b0, 1'b1, 19'b0}) begin
      bad++;
      $display("FAIL reset_dc0 got=%b exp=%b", {out_valid0, in_ready0, j0, k0, t0, p0, tc0}, {1'b0, 1'b1, 19'b0});
    end
    total++;
    if ({out_valid1, in_ready1, j1, k1, t1, p1, tc1} !== {1'b0, 1'b1, 19'b0}) begin
      bad++;
      $display("FAIL reset_dc1 got=%b exp=%b", {out_valid1, in_ready1, j1, k1, t1, p1, tc1}, {1'b0, 1'b1, 19'b0});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(4'b1010, 1'b0);
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== {1'b1, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 3'd2}) begin
      bad++;
      $display("FAIL basic1_dc0 got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, {1'b1, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 3'd2});
    end
    total++;
    if ({out_valid1, j1, k1, t1, p1, tc1} !== {1'b1, 4'b1010, 4'b0101, 4'b1010, 4'b0000, 3'd2}) begin
      bad++;
      $display("FAIL basic1_dc1 got=%b exp=%b", {out_valid1, j1, k1, t1, p1, tc1}, {1'b1, 4'b1010, 4'b0101, 4'b1010, 4'b0000, 3'd2});
    end
    send(4'b0110, 1'b0);
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== {1'b1, 4'b0100, 4'b1000, 4'b1100, 4'b1010, 3'd2}) begin
      bad++;
      $display("FAIL basic2_dc0 got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, {1'b1, 4'b0100, 4'b1000, 4'b1100, 4'b1010, 3'd2});
    end
    total++;
    if ({out_valid1, j1, k1, t1, p1, tc1} !== {1'b1, 4'b0110, 4'b1001, 4'b1100, 4'b1010, 3'd2}) begin
      bad++;
      $display("FAIL basic2_dc1 got=%b exp=%b", {out_valid1, j1, k1, t1, p1, tc1}, {1'b1, 4'b0110, 4'b1001, 4'b1100, 4'b1010, 3'd2});
    end
    @(posedge clk); #1;
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_drained got=%b exp=0", out_valid0);
    end
  endtask

  task automatic test_load;
    send(4'b1111, 1'b1);
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL load_no_output got=%b exp=0", out_valid0);
    end
    send(4'b1111, 1'b0);
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 3'd0}) begin
      bad++;
      $display("FAIL load_hold_dc0 got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 3'd0});
    end
    total++;
    if ({out_valid1, j1, k1, t1, p1, tc1} !== {1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 3'd0}) begin
      bad++;
      $display("FAIL load_hold_dc1 got=%b exp=%b", {out_valid1, j1, k1, t1, p1, tc1}, {1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 3'd0});
    end
    @(posedge clk); #1;
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL load_single_output got=%b exp=0", out_valid0);
    end
    // Back-to-back loads: last one wins.
    send(4'b0011, 1'b1);
    send(4'b0101, 1'b1);
    send(4'b0000, 1'b0);
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== {1'b1, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 3'd2}) begin
      bad++;
      $display("FAIL load_b2b_dc0 got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, {1'b1, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 3'd2});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    logic [W-1:0] w [4];
    logic [W-1:0] ep [4];
    logic [W-1:0] et [4];
    logic [W-1:0] gp [4];
    logic [W-1:0] gt [4];
    int unsigned sent, got, cyc, first_acc;
    logic acc, pop;
    w[0] = 4'b0001; w[1] = 4'b0011; w[2] = 4'b0111; w[3] = 4'b1111;
    ep[0] = 4'b0000; ep[1] = 4'b0001; ep[2] = 4'b0011; ep[3] = 4'b0111;
    et[0] = 4'b0001; et[1] = 4'b0010; et[2] = 4'b0100; et[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin gp[i] = '0; gt[i] = '0; end
    sent = 0; got = 0; cyc = 0; first_acc = 99;
    out_ready = 1'b0;
    in_valid = 1'b1; in_load = 1'b0; in_target = w[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc = in_valid & in_ready0;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 4) in_target = w[sent]; else in_valid = 1'b0;
      end
    end
    total++;
    if ({sent[2:0], in_ready0, in_ready1, out_valid0} !== {3'd2, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL stall_full got sent=%0d rdy=%b%b vld=%b exp sent=2 rdy=00 vld=1", sent, in_ready0, in_ready1, out_valid0);
    end
    out_ready = 1'b1;
    while ((got < 4 || sent < 4) && cyc < 50) begin
      @(negedge clk);
      acc = in_valid & in_ready0;
      pop = out_valid0 & out_ready;
      if (acc && first_acc == 99) first_acc = cyc;
      if (pop && got < 4) begin gp[got] = p0; gt[got] = t0; end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        sent++;
        if (sent < 4) in_target = w[sent]; else in_valid = 1'b0;
      end
      if (pop) got++;
    end
    in_valid = 1'b0;
    total++;
    if (got != 4 || sent != 4 || first_acc != 1) begin
      bad++;
      $display("FAIL stall_drain got=%0d sent=%0d first_acc=%0d exp 4 4 1", got, sent, first_acc);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({gp[i], gt[i]} !== {ep[i], et[i]}) begin
        bad++;
        $display("FAIL stall_order[%0d] got prev/t=%b/%b exp=%b/%b", i, gp[i], gt[i], ep[i], et[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(4'b1000, 1'b0);
    send(4'b0100, 1'b0);
    total++;
    if ({out_valid0, in_ready0} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_pre got=%b exp=10", {out_valid0, in_ready0});
    end
    #2; rst_n = 1'b0; #1;
    total++;
    if ({out_valid0, in_ready0, out_valid1, in_ready1} !== 4'b0101) begin
      bad++;
      $display("FAIL rstmid_async got=%b exp=0101", {out_valid0, in_ready0, out_valid1, in_ready1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== 20'b0) begin
      bad++;
      $display("FAIL rstmid_released got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, 20'b0);
    end
    out_ready = 1'b1;
    send(4'b0001, 1'b0);
    total++;
    if ({out_valid0, j0, k0, t0, p0, tc0} !== {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 3'd1}) begin
      bad++;
      $display("FAIL rstmid_first got=%b exp=%b", {out_valid0, j0, k0, t0, p0, tc0}, {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 3'd1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int unsigned nsent, cyc;
    logic [W-1:0] qm, tm, r0, r1;
    logic acc, pop;
    exp_t e;
    nsent = 0; cyc = 0;
    qm = 4'b0001;
    in_valid = 1'b1;
    in_target = 4'($urandom_range(0, 15));
    in_load = ($urandom_range(0, 9) == 0);
    while ((nsent < 1000 || sb.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid & in_ready0;
      pop = out_valid0 & out_ready;
      total++;
      if ({out_valid1, in_ready1} !== {out_valid0, in_ready0}) begin
        bad++;
        $display("FAIL rand_dut_sync got=%b exp=%b", {out_valid1, in_ready1}, {out_valid0, in_ready0});
      end
      if (pop) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rand_extra_word prev=%b exp=none", p0);
        end else begin
          e = sb.pop_front();
          tm = e.prev ^ e.tgt;
          r0 = (j0 & ~e.prev) | (~k0 & e.prev);
          r1 = (j1 & ~e.prev) | (~k1 & e.prev);
          if ({r0, r1, p0, p1, t0, t1, tc0} !== {e.tgt, e.tgt, e.prev, e.prev, tm, tm, 3'($countones(tm))}) begin
            bad++;
            $display("FAIL rand_word got next=%b/%b prev=%b/%b t=%b/%b tc=%0d exp next=%b prev=%b t=%b tc=%0d",
                     r0, r1, p0, p1, t0, t1, tc0, e.tgt, e.prev, tm, $countones(tm));
          end
        end
      end
      if (acc) begin
        if (!in_load) sb.push_back({qm, in_target});
        qm = in_target;
        nsent++;
      end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (nsent < 1000) begin
          in_target = 4'($urandom_range(0, 15));
          in_load = ($urandom_range(0, 9) == 0);
        end else begin
          in_valid = 1'b0; in_load = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (nsent != 1000 || sb.size() != 0) begin
      bad++;
      $display("FAIL rand_complete sent=%0d pending=%0d exp 1000 0", nsent, sb.size());
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL rand_no_trailing got=%b exp=0", out_valid0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_load;
    test_stall;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
